// File: rtl/cluster_periph_demux_pkg.sv
// Shared definitions for the cluster peripheral demux: the SPER_*_ID slot map,
// the error read-data constant, the tracker entry layout and a slot-map helper.
package cluster_periph_demux_pkg;

  // Slot map of the cluster peripheral plugs. Slot 3 is a hole in the map.
  localparam int unsigned SPER_EOC_ID         = 0;
  localparam int unsigned SPER_TIMER_ID       = 1;
  localparam int unsigned SPER_EVENT_U_ID     = 2;
  localparam int unsigned SPER_RSVD_ID        = 3;
  localparam int unsigned SPER_HWPE_ID        = 4;
  localparam int unsigned SPER_ICACHE_CTRL_ID = 5;
  localparam int unsigned SPER_DMA_CL_ID      = 6;
  localparam int unsigned SPER_DMA_FC_ID      = 7;
  localparam int unsigned SPER_JPEG_ID        = 8;
  localparam int unsigned SPER_EXT_ID         = 9;

  // Read data returned for accesses that hit an unmapped slot.
  localparam logic [31:0] PERIPH_DEMUX_ERR_RDATA = 32'hBADA_CCE5;

  // Widest transaction ID a tracker entry can hold.
  localparam int unsigned PERIPH_DEMUX_MAX_ID_WIDTH = 8;

  typedef logic [3:0] per_slot_t;

  // One outstanding transaction: target plug, error flag and initiator ID.
  typedef struct packed {
    per_slot_t                            slot;
    logic                                 err;
    logic [PERIPH_DEMUX_MAX_ID_WIDTH-1:0] id;
  } periph_trk_entry_t;

  // A slot is backed by a plug when it exists and is not the reserved hole.
  function automatic logic periph_slot_mapped(input per_slot_t slot,
                                              input int unsigned nb_speriphs);
    return ({28'd0, slot} < nb_speriphs) && ({28'd0, slot} != SPER_RSVD_ID);
  endfunction

endpackage

// File: rtl/cluster_periph_demux_if.sv
// Master-side request/response bus of the cluster peripheral demux.
//
// Handshake: the master raises req with stable add/wen/wdata/be/id and holds
// them until a cycle where gnt is also high; that cycle (req & gnt) is the
// transfer. gnt may be high without req and then means nothing. Every
// transfer produces exactly one single-cycle r_valid pulse carrying
// r_rdata/r_opc/r_id, in request order; the master cannot stall responses.
interface cluster_periph_demux_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 5
);
  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

  logic                  req;
  logic                  gnt;
  logic [ADDR_WIDTH-1:0] add;
  logic                  wen;
  logic [DATA_WIDTH-1:0] wdata;
  logic [BE_WIDTH-1:0]   be;
  logic [ID_WIDTH-1:0]   id;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_opc;
  logic [ID_WIDTH-1:0]   r_id;

  modport master (
    output req, add, wen, wdata, be, id,
    input  gnt, r_valid, r_rdata, r_opc, r_id
  );

  modport slave (
    input  req, add, wen, wdata, be, id,
    output gnt, r_valid, r_rdata, r_opc, r_id
  );

endinterface

// File: rtl/cluster_periph_demux_tracker.sv
// Outstanding-transaction FIFO for the peripheral demux. Exposes the head
// entry, full/empty flags and the slot of the most recently pushed entry,
// which the demux uses to keep all in-flight traffic on a single plug.
module cluster_periph_demux_tracker
  import cluster_periph_demux_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  periph_trk_entry_t entry_i,
  input  logic              pop_i,
  output periph_trk_entry_t head_o,
  output logic              full_o,
  output logic              empty_o,
  output per_slot_t         last_slot_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  periph_trk_entry_t mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  per_slot_t         last_slot_q, last_slot_d;
  logic              push_ok, pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o      = (cnt_q == CNT_W'(DEPTH));
  assign empty_o     = (cnt_q == '0);
  assign push_ok     = push_i & ~full_o;
  assign pop_ok      = pop_i & ~empty_o;
  assign head_o      = mem_q[rd_ptr_q];
  assign last_slot_o = last_slot_q;

  // Next-state of pointers, occupancy and last-pushed slot.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    last_slot_d = last_slot_q;
    if (push_ok) begin
      wr_ptr_d    = ptr_inc(wr_ptr_q);
      last_slot_d = entry_i.slot;
    end
    if (pop_ok) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state; reset empties the FIFO.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      last_slot_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      last_slot_q <= last_slot_d;
    end
  end

  // Entry storage; contents are only meaningful while counted as occupied.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= entry_i;
    end
  end

endmodule

// File: rtl/cluster_periph_demux.sv
// Cluster peripheral demux: routes one request stream to NB_SPERIPHS plugs
// by address slot and returns responses in order with their IDs.
// Optional feature macro: PERIPH_DEMUX_ERR_RESP_EN. When defined, unmapped
// slots are answered locally with an error response; when undefined they are
// routed to the external plug (SPER_EXT_ID), which must exist.
module cluster_periph_demux
  import cluster_periph_demux_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned ID_WIDTH        = 5,
  parameter int unsigned NB_SPERIPHS     = 10,
  parameter int unsigned ADDR_SEL_LSB    = 10,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  cluster_periph_demux_if.slave             bus_s,
  output logic [NB_SPERIPHS-1:0]            per_req_o,
  output logic [ADDR_WIDTH-1:0]             per_add_o,
  output logic                              per_wen_o,
  output logic [DATA_WIDTH-1:0]             per_wdata_o,
  output logic [DATA_WIDTH/8-1:0]           per_be_o,
  output logic [ID_WIDTH-1:0]               per_id_o,
  input  logic [NB_SPERIPHS-1:0]            per_gnt_i,
  input  logic [NB_SPERIPHS-1:0]            per_r_valid_i,
  input  logic [NB_SPERIPHS*DATA_WIDTH-1:0] per_r_rdata_i,
  input  logic [NB_SPERIPHS-1:0]            per_r_opc_i
);

  per_slot_t               req_slot, tgt_slot, trk_last_slot;
  logic                    req_mapped, req_err;
  logic [NB_SPERIPHS-1:0]  tgt_onehot, head_onehot;
  logic                    stall, gnt, push, pop, head_rsp;
  logic                    trk_full, trk_empty;
  periph_trk_entry_t       push_entry, trk_head;
  logic [DATA_WIDTH-1:0]   head_rdata;
  logic                    head_opc;

  logic                    r_valid_q;
  logic [DATA_WIDTH-1:0]   r_rdata_q;
  logic                    r_opc_q;
  logic [ID_WIDTH-1:0]     r_id_q;

  assign req_slot   = bus_s.add[ADDR_SEL_LSB+3:ADDR_SEL_LSB];
  assign req_mapped = periph_slot_mapped(req_slot, NB_SPERIPHS);

`ifdef PERIPH_DEMUX_ERR_RESP_EN
  assign req_err  = ~req_mapped;
  assign tgt_slot = req_slot;
`else
  assign req_err  = 1'b0;
  assign tgt_slot = req_mapped ? req_slot : per_slot_t'(SPER_EXT_ID);
`endif

  // Shared request fields go to every plug; only per_req_o selects one.
  assign per_add_o   = bus_s.add;
  assign per_wen_o   = bus_s.wen;
  assign per_wdata_o = bus_s.wdata;
  assign per_be_o    = bus_s.be;
  assign per_id_o    = bus_s.id;

  // Keeping all in-flight traffic on one plug guarantees in-order responses
  // without reorder buffering. Only registered tracker state feeds the stall,
  // so a pop never opens the grant in the same cycle.
  assign stall = trk_full | (~trk_empty & (tgt_slot != trk_last_slot));

  // Decode target and head plugs; an error head owns no plug.
  always_comb begin
    tgt_onehot  = '0;
    head_onehot = '0;
    for (int p = 0; p < NB_SPERIPHS; p++) begin
      tgt_onehot[p]  = (tgt_slot == per_slot_t'(p));
      head_onehot[p] = ~trk_head.err & (trk_head.slot == per_slot_t'(p));
    end
  end

  // Request routing and grant; everything is held off during reset.
  always_comb begin
    per_req_o = '0;
    gnt       = 1'b0;
    if (!rst_i && !stall) begin
      if (req_err) begin
        gnt = bus_s.req;
      end else begin
        per_req_o = tgt_onehot & {NB_SPERIPHS{bus_s.req}};
        gnt       = |(per_gnt_i & tgt_onehot);
      end
    end
  end

  assign bus_s.gnt = gnt;
  assign push      = bus_s.req & gnt;

  always_comb begin
    push_entry      = '0;
    push_entry.slot = tgt_slot;
    push_entry.err  = req_err;
    push_entry.id   = PERIPH_DEMUX_MAX_ID_WIDTH'(bus_s.id);
  end

  cluster_periph_demux_tracker #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_tracker (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push),
    .entry_i     (push_entry),
    .pop_i       (pop),
    .head_o      (trk_head),
    .full_o      (trk_full),
    .empty_o     (trk_empty),
    .last_slot_o (trk_last_slot)
  );

  // Select the response of the plug the head entry is waiting on.
  always_comb begin
    head_rdata = '0;
    head_opc   = 1'b0;
    for (int p = 0; p < NB_SPERIPHS; p++) begin
      if (head_onehot[p]) begin
        head_rdata = per_r_rdata_i[p*DATA_WIDTH +: DATA_WIDTH];
        head_opc   = per_r_opc_i[p];
      end
    end
  end

  assign head_rsp = |(per_r_valid_i & head_onehot);
  // Error entries retire unconditionally; mapped ones wait for their plug.
  assign pop      = ~trk_empty & (trk_head.err | head_rsp);

  // Single register stage on the response path.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid_q <= 1'b0;
      r_rdata_q <= '0;
      r_opc_q   <= 1'b0;
      r_id_q    <= '0;
    end else begin
      r_valid_q <= pop;
      if (pop) begin
        r_id_q <= trk_head.id[ID_WIDTH-1:0];
`ifdef PERIPH_DEMUX_ERR_RESP_EN
        if (trk_head.err) begin
          r_rdata_q <= DATA_WIDTH'(PERIPH_DEMUX_ERR_RDATA);
          r_opc_q   <= 1'b1;
        end else begin
          r_rdata_q <= head_rdata;
          r_opc_q   <= head_opc;
        end
`else
        r_rdata_q <= head_rdata;
        r_opc_q   <= head_opc;
`endif
      end
    end
  end

  assign bus_s.r_valid = r_valid_q;
  assign bus_s.r_rdata = r_rdata_q;
  assign bus_s.r_opc   = r_opc_q;
  assign bus_s.r_id    = r_id_q;

  // Entry ID bits above ID_WIDTH are always zero.
  if (ID_WIDTH < PERIPH_DEMUX_MAX_ID_WIDTH) begin : g_id_pad
    logic unused_id_pad;
    assign unused_id_pad = ^trk_head.id[PERIPH_DEMUX_MAX_ID_WIDTH-1:ID_WIDTH];
  end

  // A response on any plug other than the head's breaks response ordering.
  assert property (@(posedge clk_i) disable iff (rst_i)
    trk_empty || ((per_r_valid_i & ~head_onehot) == '0));

endmodule

// File: tb/tb_cluster_periph_demux.sv
// Directed bench for cluster_periph_demux: routing, stalls, error slots,
// full-tracker pop/push and mid-transaction reset.
module tb_cluster_periph_demux;
  import cluster_periph_demux_pkg::*;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned IW  = 5;
  localparam int unsigned NB  = 10;
  localparam int unsigned SEL = 10;
  localparam int unsigned MO  = 2;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic [NB-1:0]     per_req_o;
  logic [AW-1:0]     per_add_o;
  logic              per_wen_o;
  logic [DW-1:0]     per_wdata_o;
  logic [DW/8-1:0]   per_be_o;
  logic [IW-1:0]     per_id_o;
  logic [NB-1:0]     per_gnt_i;
  logic [NB-1:0]     per_r_valid_i;
  logic [NB*DW-1:0]  per_r_rdata_i;
  logic [NB-1:0]     per_r_opc_i;

  int n_vec = 0;
  int n_err = 0;

  cluster_periph_demux_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) mst_bus ();

  cluster_periph_demux #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW),
    .NB_SPERIPHS(NB), .ADDR_SEL_LSB(SEL), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .bus_s(mst_bus),
    .per_req_o(per_req_o), .per_add_o(per_add_o), .per_wen_o(per_wen_o),
    .per_wdata_o(per_wdata_o), .per_be_o(per_be_o), .per_id_o(per_id_o),
    .per_gnt_i(per_gnt_i), .per_r_valid_i(per_r_valid_i),
    .per_r_rdata_i(per_r_rdata_i), .per_r_opc_i(per_r_opc_i)
  );

  // Clock and watchdog.
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  // Driver tasks.
  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic set_req(input int slot, input logic wen, input logic [IW-1:0] id,
                         input logic [DW-1:0] wdata);
    mst_bus.req   = 1'b1;
    mst_bus.add   = (AW'(slot) << SEL) | AW'(32'h24);
    mst_bus.wen   = wen;
    mst_bus.wdata = wdata;
    mst_bus.be    = '1;
    mst_bus.id    = id;
  endtask

  task automatic clr_req();
    mst_bus.req   = 1'b0;
    mst_bus.add   = '0;
    mst_bus.wen   = 1'b0;
    mst_bus.wdata = '0;
    mst_bus.be    = '0;
    mst_bus.id    = '0;
  endtask

  task automatic plug_rsp(input int p, input logic [DW-1:0] data, input logic opc);
    per_r_valid_i                = '0;
    per_r_valid_i[p]             = 1'b1;
    per_r_rdata_i[p*DW +: DW]    = data;
    per_r_opc_i[p]               = opc;
  endtask

  task automatic plug_idle();
    per_r_valid_i = '0;
  endtask

  // Scenario tasks.
  task automatic test_reset();
    tick(); set_req(1, 1'b1, 5'd3, '0); #1;
    n_vec++; if (mst_bus.gnt !== 1'b0) begin n_err++; $display("FAIL rst_gnt: got %b want 0", mst_bus.gnt); end
    n_vec++; if (per_req_o !== 10'b0) begin n_err++; $display("FAIL rst_per_req: got %b want 0", per_req_o); end
    tick(); #1;
    n_vec++; if (mst_bus.r_valid !== 1'b0) begin n_err++; $display("FAIL rst_r_valid: got %b want 0", mst_bus.r_valid); end
    n_vec++; if (mst_bus.r_rdata !== 32'h0) begin n_err++; $display("FAIL rst_r_rdata: got %h want 0", mst_bus.r_rdata); end
    n_vec++; if (mst_bus.r_opc !== 1'b0) begin n_err++; $display("FAIL rst_r_opc: got %b want 0", mst_bus.r_opc); end
    n_vec++; if (mst_bus.r_id !== 5'd0) begin n_err++; $display("FAIL rst_r_id: got %0d want 0", mst_bus.r_id); end
    tick(); rst_i = 1'b0; clr_req();
  endtask

  task automatic test_read_timer();
    tick(); set_req(1, 1'b1, 5'd7, '0); #1;
    n_vec++; if (per_req_o !== 10'b00_0000_0010) begin n_err++; $display("FAIL rd_per_req: got %b want 0000000010", per_req_o); end
    n_vec++; if (mst_bus.gnt !== 1'b1) begin n_err++; $display("FAIL rd_gnt: got %b want 1", mst_bus.gnt); end
    n_vec++; if (per_add_o !== 32'h0000_0424) begin n_err++; $display("FAIL rd_per_add: got %h want 00000424", per_add_o); end
    n_vec++; if (per_wen_o !== 1'b1 || per_id_o !== 5'd7) begin n_err++; $display("FAIL rd_per_fields: got wen %b id %0d want 1 7", per_wen_o, per_id_o); end
    tick(); clr_req(); plug_rsp(1, 32'h0000_1234, 1'b0); #1;
    n_vec++; if (mst_bus.r_valid !== 1'b0) begin n_err++; $display("FAIL rd_early_valid: got %b want 0", mst_bus.r_valid); end
    tick(); plug_idle(); #1;
    n_vec++; if (mst_bus.r_valid !== 1'b1) begin n_err++; $display("FAIL rd_r_valid: got %b want 1", mst_bus.r_valid); end
    n_vec++; if (mst_bus.r_rdata !== 32'h0000_1234) begin n_err++; $display("FAIL rd_r_rdata: got %h want 00001234", mst_bus.r_rdata); end
    n_vec++; if (mst_bus.r_opc !== 1'b0 || mst_bus.r_id !== 5'd7) begin n_err++; $display("FAIL rd_r_opc_id: got %b %0d want 0 7", mst_bus.r_opc, mst_bus.r_id); end
    tick(); #1;
    n_vec++; if (mst_bus.r_valid !== 1'b0) begin n_err++; $display("FAIL rd_pulse: got %b want 0", mst_bus.r_valid); end
  endtask

  task automatic test_back_to_back();
    tick(); set_req(0, 1'b0, 5'd1, 32'h11); #1;
    n_vec++; if (mst_bus.gnt !== 1'b1 || per_req_o !== 10'b1) begin n_err++; $display("FAIL b2b_gnt1: got %b %b want 1 0000000001", mst_bus.gnt, per_req_o); end
    n_vec++; if (per_wdata_o !== 32'h11 || per_wen_o !== 1'b0) begin n_err++; $display("FAIL b2b_wdata: got %h %b want 11 0", per_wdata_o, per_wen_o); end
    tick(); set_req(0, 1'b0, 5'd2, 32'h22); #1;
    n_vec++; if (mst_bus.gnt !== 1'b1) begin n_err++; $display("FAIL b2b_gnt2: got %b want 1", mst_bus.gnt); end
    tick(); set_req(0, 1'b0, 5'd3, 32'h33); #1;
    n_vec++; if (mst_bus.gnt !== 1'b0 || per_req_o !== 10'b0) begin n_err++; $display("FAIL b2b_full_stall: got %b %b want 0 0", mst_bus.gnt, per_req_o); end
    tick(); plug_rsp(0, 32'hA1, 1'b0); #1;
    n_vec++; if (mst_bus.gnt !== 1'b0 || mst_bus.r_valid !== 1'b0) begin n_err++; $display("FAIL b2b_stall2: got gnt %b rv %b want 0 0", mst_bus.gnt, mst_bus.r_valid); end
    tick(); plug_rsp(0, 32'hA2, 1'b0); #1;
    n_vec++; if (mst_bus.gnt !== 1'b1 || per_req_o !== 10'b1) begin n_err++; $display("FAIL b2b_gnt3: got %b %b want 1 0000000001", mst_bus.gnt, per_req_o); end
    n_vec++; if (mst_bus.r_valid !== 1'b1 || mst_bus.r_id !== 5'd1 || mst_bus.r_rdata !== 32'hA1) begin n_err++; $display("FAIL b2b_rsp1: got %b %0d %h want 1 1 a1", mst_bus.r_valid, mst_bus.r_id, mst_bus.r_rdata); end
    tick(); clr_req(); plug_idle(); #1;
    n_vec++; if (mst_bus.r_valid !== 1'b1 || mst_bus.r_id !== 5'd2 || mst_bus.r_rdata !== 32'hA2) begin n_err++; $display("FAIL b2b_rsp2: got %b %0d %h want 1 2 a2", mst_bus.r_valid, mst_bus.r_id, mst_bus.r_rdata); end
    tick(); #1;
    n_vec++; if (mst_bus.r_valid !== 1'b0) begin n_err++; $display("FAIL b2b_gap: got %b want 0", mst_bus.r_valid); end
    tick(); plug_rsp(0, 32'hA3, 1'b1); #1;
    tick(); plug_idle(); #1;
    n_vec++; if (mst_bus.r_valid !== 1'b1 || mst_bus.r_id !== 5'd3 || mst_bus.r_rdata !== 32'hA3 || mst_bus.r_opc !== 1'b1) begin n_err++; $display("FAIL b2b_rsp3: got %b %0d %h %b want 1 3 a3 1", mst_bus.r_valid, mst_bus.r_id, mst_bus.r_rdata, mst_bus.r_opc); end
  endtask

  task automatic test_unmapped(input int slot, input logic [IW-1:0] id);
    tick(); set_req(slot, 1'b1, id, '0); #1;
`ifdef PERIPH_DEMUX_ERR_RESP_EN
    n_vec++; if (per_req_o !== 10'b0 || mst_bus.gnt !== 1'b1) begin n_err++; $display("FAIL unm_req_s%0d: got %b %b want 0 1", slot, per_req_o, mst_bus.gnt); end
    tick(); clr_req(); #1;
`else
    n_vec++; if (per_req_o !== 10'b10_0000_0000 || mst_bus.gnt !== 1'b1) begin n_err++; $display("FAIL unm_req_s%0d: got %b %b want 1000000000 1", slot, per_req_o, mst_bus.gnt); end
    tick(); clr_req(); plug_rsp(9, 32'h0000_9009, 1'b0); #1;
`endif
    n_vec++; if (mst_bus.r_valid !== 1'b0) begin n_err++; $display("FAIL unm_early_s%0d: got %b want 0", slot, mst_bus.r_valid); end
    tick(); plug_idle(); #1;
    n_vec++; if (mst_bus.r_valid !== 1'b1 || mst_bus.r_id !== id) begin n_err++; $display("FAIL unm_valid_s%0d: got %b %0d want 1 %0d", slot, mst_bus.r_valid, mst_bus.r_id, id); end
`ifdef PERIPH_DEMUX_ERR_RESP_EN
    n_vec++; if (mst_bus.r_rdata !== 32'hBADACCE5 || mst_bus.r_opc !== 1'b1) begin n_err++; $display("FAIL unm_rsp_s%0d: got %h %b want badacce5 1", slot, mst_bus.r_rdata, mst_bus.r_opc); end
`else
    n_vec++; if (mst_bus.r_rdata !== 32'h0000_9009 || mst_bus.r_opc !== 1'b0) begin n_err++; $display("FAIL unm_rsp_s%0d: got %h %b want 00009009 0", slot, mst_bus.r_rdata, mst_bus.r_opc); end
`endif
  endtask

  task automatic test_stall_diff_slot();
    tick(); set_req(2, 1'b1, 5'd1, '0); #1;
    n_vec++; if (mst_bus.gnt !== 1'b1 || per_req_o !== 10'b00_0000_0100) begin n_err++; $display("FAIL sds_gnt2: got %b %b want 1 0000000100", mst_bus.gnt, per_req_o); end
    tick(); set_req(6, 1'b1, 5'd2, '0); #1;
    n_vec++; if (mst_bus.gnt !== 1'b0 || per_req_o !== 10'b0) begin n_err++; $display("FAIL sds_stall1: got %b %b want 0 0", mst_bus.gnt, per_req_o); end
    tick(); plug_rsp(2, 32'h2222, 1'b0); #1;
    n_vec++; if (mst_bus.gnt !== 1'b0) begin n_err++; $display("FAIL sds_stall2: got %b want 0", mst_bus.gnt); end
    tick(); plug_idle(); #1;
    n_vec++; if (mst_bus.gnt !== 1'b1 || per_req_o !== 10'b00_0100_0000 || per_id_o !== 5'd2) begin n_err++; $display("FAIL sds_gnt6: got %b %b %0d want 1 0001000000 2", mst_bus.gnt, per_req_o, per_id_o); end
    n_vec++; if (mst_bus.r_valid !== 1'b1 || mst_bus.r_id !== 5'd1 || mst_bus.r_rdata !== 32'h2222) begin n_err++; $display("FAIL sds_rsp2: got %b %0d %h want 1 1 2222", mst_bus.r_valid, mst_bus.r_id, mst_bus.r_rdata); end
    tick(); clr_req(); plug_rsp(6, 32'h6666, 1'b0); #1;
    n_vec++; if (mst_bus.r_valid !== 1'b0) begin n_err++; $display("FAIL sds_gap: got %b want 0", mst_bus.r_valid); end
    tick(); plug_idle(); #1;
    n_vec++; if (mst_bus.r_valid !== 1'b1 || mst_bus.r_id !== 5'd2 || mst_bus.r_rdata !== 32'h6666) begin n_err++; $display("FAIL sds_rsp6: got %b %0d %h want 1 2 6666", mst_bus.r_valid, mst_bus.r_id, mst_bus.r_rdata); end
  endtask

  task automatic test_full_pop_push();
    tick(); set_req(4, 1'b1, 5'd1, '0); #1;
    tick(); set_req(4, 1'b1, 5'd2, '0); #1;
    n_vec++; if (mst_bus.gnt !== 1'b1) begin n_err++; $display("FAIL fpp_fill: got %b want 1", mst_bus.gnt); end
    tick(); set_req(4, 1'b1, 5'd3, '0); plug_rsp(4, 32'h41, 1'b0); #1;
    n_vec++; if (mst_bus.gnt !== 1'b0) begin n_err++; $display("FAIL fpp_no_comb_gnt: got %b want 0", mst_bus.gnt); end
    tick(); plug_rsp(4, 32'h42, 1'b0); #1;
    n_vec++; if (mst_bus.gnt !== 1'b1) begin n_err++; $display("FAIL fpp_gnt_next: got %b want 1", mst_bus.gnt); end
    n_vec++; if (mst_bus.r_valid !== 1'b1 || mst_bus.r_id !== 5'd1 || mst_bus.r_rdata !== 32'h41) begin n_err++; $display("FAIL fpp_rsp1: got %b %0d %h want 1 1 41", mst_bus.r_valid, mst_bus.r_id, mst_bus.r_rdata); end
    tick(); clr_req(); plug_rsp(4, 32'h43, 1'b0); #1;
    n_vec++; if (mst_bus.r_valid !== 1'b1 || mst_bus.r_id !== 5'd2 || mst_bus.r_rdata !== 32'h42) begin n_err++; $display("FAIL fpp_rsp2: got %b %0d %h want 1 2 42", mst_bus.r_valid, mst_bus.r_id, mst_bus.r_rdata); end
    tick(); plug_idle(); #1;
    n_vec++; if (mst_bus.r_valid !== 1'b1 || mst_bus.r_id !== 5'd3 || mst_bus.r_rdata !== 32'h43) begin n_err++; $display("FAIL fpp_rsp3: got %b %0d %h want 1 3 43", mst_bus.r_valid, mst_bus.r_id, mst_bus.r_rdata); end
    tick(); #1;
    n_vec++; if (mst_bus.r_valid !== 1'b0) begin n_err++; $display("FAIL fpp_no_dup: got %b want 0", mst_bus.r_valid); end
  endtask

  task automatic test_reset_mid();
    tick(); set_req(5, 1'b1, 5'd1, '0); #1;
    tick(); set_req(5, 1'b1, 5'd2, '0); #1;
    n_vec++; if (mst_bus.gnt !== 1'b1) begin n_err++; $display("FAIL rmid_fill: got %b want 1", mst_bus.gnt); end
    tick(); rst_i = 1'b1; set_req(5, 1'b1, 5'd3, '0); #1;
    n_vec++; if (mst_bus.gnt !== 1'b0 || per_req_o !== 10'b0) begin n_err++; $display("FAIL rmid_gnt_in_rst: got %b %b want 0 0", mst_bus.gnt, per_req_o); end
    tick(); rst_i = 1'b0; clr_req(); plug_rsp(5, 32'h55, 1'b1); #1;
    n_vec++; if (mst_bus.r_valid !== 1'b0 || mst_bus.r_rdata !== 32'h0 || mst_bus.r_opc !== 1'b0 || mst_bus.r_id !== 5'd0) begin n_err++; $display("FAIL rmid_r_clear: got %b %h %b %0d want 0 0 0 0", mst_bus.r_valid, mst_bus.r_rdata, mst_bus.r_opc, mst_bus.r_id); end
    tick(); plug_rsp(5, 32'h56, 1'b0); #1;
    n_vec++; if (mst_bus.r_valid !== 1'b0) begin n_err++; $display("FAIL rmid_late1: got %b want 0", mst_bus.r_valid); end
    tick(); plug_idle(); #1;
    n_vec++; if (mst_bus.r_valid !== 1'b0) begin n_err++; $display("FAIL rmid_late2: got %b want 0", mst_bus.r_valid); end
    tick(); set_req(5, 1'b1, 5'd4, '0); #1;
    n_vec++; if (mst_bus.gnt !== 1'b1) begin n_err++; $display("FAIL rmid_regnt: got %b want 1", mst_bus.gnt); end
    tick(); clr_req(); plug_rsp(5, 32'h57, 1'b0); #1;
    tick(); plug_idle(); #1;
    n_vec++; if (mst_bus.r_valid !== 1'b1 || mst_bus.r_id !== 5'd4 || mst_bus.r_rdata !== 32'h57) begin n_err++; $display("FAIL rmid_recover: got %b %0d %h want 1 4 57", mst_bus.r_valid, mst_bus.r_id, mst_bus.r_rdata); end
  endtask

  initial begin
    clr_req();
    per_gnt_i     = '1;
    per_r_valid_i = '0;
    per_r_rdata_i = '0;
    per_r_opc_i   = '0;
    test_reset();
    test_read_timer();
    test_back_to_back();
    test_unmapped(3, 5'd5);
    test_unmapped(10, 5'd6);
    test_unmapped(15, 5'd9);
    test_stall_diff_slot();
    test_full_pop_push();
    test_reset_mid();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
